cnn_load_receiver: RTL and testbench

- Slave-side write receiver between the DMA write master and the CNN accelerator.
- Accepts single-beat writes, decodes the CNN image/weight/bias address windows, and streams each word into the matching local buffer write port.
- Mapping writes mark a region as loaded. When all regions are loaded, it launches the CNN and reports completion to the CPU through a level interrupt.

---
 rtl/cnn_load_receiver.sv | 143 ++++++++++++++
 tb/tb_cnn_load_receiver.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_load_receiver.sv
// Write receiver that decodes DMA beats into the CNN image/weight/bias buffers,
// tracks region-loaded flags, launches the CNN and raises a level interrupt on completion.
module cnn_load_receiver #(
  parameter int IMG_DEPTH = 3072,
  parameter int W_DEPTH   = 1024,
  parameter int B_DEPTH   = 64,
  parameter int BUF_AW    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wvalid,
  output logic              wready,
  input  logic [31:0]       waddr,
  input  logic [31:0]       wdata,
  output logic              buf_we,
  output logic [1:0]        buf_sel,
  output logic [BUF_AW-1:0] buf_addr,
  output logic [31:0]       buf_wdata,
  output logic              cnn_start,
  input  logic              cnn_done,
  output logic              irq,
  input  logic              irq_clr,
  output logic              err,
  output logic [BUF_AW:0]   img_words
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic img_rdy, w_rdy, b_rdy;
  logic flags_full;

  logic        accept, ignore, live;
  logic [15:0] region;
  logic [13:0] offset;
  logic        hit_img, hit_w, hit_b;
  logic        ok_img, ok_w, ok_b, ok_any;
  logic        map_img, map_w, map_b, map_any;
  logic        do_write, bad_beat;
  logic [1:0]  sel_next;
  logic        unused_bits;

  assign unused_bits = ^waddr[1:0];

  assign region     = waddr[31:16];
  assign offset     = waddr[15:2];
  assign flags_full = img_rdy & w_rdy & b_rdy;

  assign accept = wvalid & wready;
  // The cycle that completes the flag set is already committed to START; drop its beat.
  assign ignore = (state_reg == S_LOAD) && flags_full;
  assign live   = accept && !ignore;

  assign hit_img = (region == 16'hd555);
  assign hit_w   = (region == 16'hd333);
  assign hit_b   = (region == 16'hd444);

  assign ok_img = hit_img && (32'(offset) < IMG_DEPTH);
  assign ok_w   = hit_w   && (32'(offset) < W_DEPTH);
  assign ok_b   = hit_b   && (32'(offset) < B_DEPTH);
  assign ok_any = ok_img | ok_w | ok_b;

  assign map_img = (waddr == 32'hdcccffff);
  assign map_w   = (waddr == 32'hdccc0000);
  assign map_b   = (waddr == 32'hdccc1111);
  assign map_any = map_img | map_w | map_b;

  assign do_write = live && ok_any;
  assign bad_beat = live && !ok_any && !map_any;

  always_comb begin
    sel_next = 2'd0;
    if (ok_w) begin
      sel_next = 2'd1;
    end else if (ok_b) begin
      sel_next = 2'd2;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_LOAD;
      S_LOAD:  if (flags_full) state_next = S_START;
      S_START: state_next = S_RUN;
      S_RUN:   if (cnn_done) state_next = S_DONE;
      S_DONE:  if (irq_clr) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      wready    <= 1'b0;
      cnn_start <= 1'b0;
      irq       <= 1'b0;
      buf_we    <= 1'b0;
      buf_sel   <= 2'd0;
      buf_addr  <= '0;
      buf_wdata <= '0;
      err       <= 1'b0;
      img_words <= '0;
      img_rdy   <= 1'b0;
      w_rdy     <= 1'b0;
      b_rdy     <= 1'b0;
    end else begin
      state_reg <= state_next;
      wready    <= (state_next == S_IDLE) || (state_next == S_LOAD);
      cnn_start <= (state_next == S_START);
      irq       <= (state_next == S_DONE);
      buf_we    <= do_write;
      if (do_write) begin
        buf_sel   <= sel_next;
        buf_addr  <= offset[BUF_AW-1:0];
        buf_wdata <= wdata;
      end
      if (bad_beat) begin
        err <= 1'b1;
      end
      if (live && wdata[0]) begin
        if (map_img) img_rdy <= 1'b1;
        if (map_w)   w_rdy   <= 1'b1;
        if (map_b)   b_rdy   <= 1'b1;
      end
      // Weights and bias persist across runs; only the image must be reloaded.
      if ((state_reg == S_DONE) && (state_next == S_IDLE)) begin
        img_rdy   <= 1'b0;
        img_words <= '0;
      end else if (do_write && ok_img && (img_words != '1)) begin
        img_words <= img_words + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cnn_load_receiver.sv
// Self-checking bench for cnn_load_receiver: decode table, directed run/interrupt
// sequences, img_words saturation and a randomized load phase against a reference model.
module tb_cnn_load_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic        buf_we;
  logic [1:0]  buf_sel;
  logic [11:0] buf_addr;
  logic [31:0] buf_wdata;
  logic        cnn_start;
  logic        cnn_done = 1'b0;
  logic        irq;
  logic        irq_clr = 1'b0;
  logic        err;
  logic [12:0] img_words;

  int n_pass = 0;
  int n_total = 0;

  cnn_load_receiver #(
    .IMG_DEPTH(3072), .W_DEPTH(1024), .B_DEPTH(64), .BUF_AW(12)
  ) dut (
    .clk(clk), .rst(rst), .wvalid(wvalid), .wready(wready), .waddr(waddr), .wdata(wdata),
    .buf_we(buf_we), .buf_sel(buf_sel), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .cnn_start(cnn_start), .cnn_done(cnn_done), .irq(irq), .irq_clr(irq_clr),
    .err(err), .img_words(img_words)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic [1:0]  sel;
    logic [11:0] waddr_exp;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] d);
    $display("beat addr=%08h data=%08h", a, d);
    waddr = a;
    wdata = d;
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    wvalid = 1'b0;
    cnn_done = 1'b0;
    irq_clr = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic pulse_done();
    cnn_done = 1'b1;
    tick();
    cnn_done = 1'b0;
  endtask

  task automatic pulse_clr();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
  endtask

  // Watch cnn_start over n samples and require it only at sample index want (-1: never).
  task automatic expect_start(input string name, input int want, input int n);
    int seen = -1;
    int count = 0;
    for (int i = 0; i < n; i++) begin
      if (cnn_start) begin
        count++;
        if (seen < 0) seen = i;
      end
      tick();
    end
    check({name, "_index"}, seen, want);
    check({name, "_count"}, count, (want < 0) ? 0 : 1);
  endtask

  initial begin
    logic [11:0] last_addr;
    logic [1:0]  last_sel;
    logic [31:0] last_data;
    int          cnt_exp;
    logic        err_exp;

    tbl[0]  = '{32'hd5550000, 32'ha5a50000, 1'b1, 2'd0, 12'd0};
    tbl[1]  = '{32'hd5550004, 32'ha5a50001, 1'b1, 2'd0, 12'd1};
    tbl[2]  = '{32'hd5550008, 32'ha5a50002, 1'b1, 2'd0, 12'd2};
    tbl[3]  = '{32'hd555000c, 32'ha5a50003, 1'b1, 2'd0, 12'd3};
    tbl[4]  = '{32'hd3330ffc, 32'h11112222, 1'b1, 2'd1, 12'd1023};
    tbl[5]  = '{32'hd3331000, 32'h33334444, 1'b0, 2'd0, 12'd0};
    tbl[6]  = '{32'hd44400fc, 32'h55556666, 1'b1, 2'd2, 12'd63};
    tbl[7]  = '{32'hd4440100, 32'h77778888, 1'b0, 2'd0, 12'd0};
    tbl[8]  = '{32'hd5552ffc, 32'h9999aaaa, 1'b1, 2'd0, 12'd3071};
    tbl[9]  = '{32'hd5553000, 32'hbbbbcccc, 1'b0, 2'd0, 12'd0};
    tbl[10] = '{32'h12340000, 32'hddddeeee, 1'b0, 2'd0, 12'd0};
    tbl[11] = '{32'hdccc0000, 32'h00000000, 1'b0, 2'd0, 12'd0};

    // Reset state, sampled while reset is held.
    rst = 1'b0;
    tick();
    tick();
    check("rst_wready", wready, 0);
    check("rst_buf_we", buf_we, 0);
    check("rst_buf_sel", buf_sel, 0);
    check("rst_buf_addr", buf_addr, 0);
    check("rst_buf_wdata", buf_wdata, 0);
    check("rst_cnn_start", cnn_start, 0);
    check("rst_irq", irq, 0);
    check("rst_err", err, 0);
    check("rst_img_words", img_words, 0);
    rst = 1'b1;
    tick();
    check("idle_wready", wready, 1);

    // Decode table: back-to-back beats, each result visible one cycle later.
    cnt_exp = 0;
    err_exp = 1'b0;
    last_addr = '0;
    last_sel = '0;
    last_data = '0;
    for (int i = 0; i < 12; i++) begin
      $display("vec %0d addr=%08h data=%08h", i, tbl[i].addr, tbl[i].data);
      waddr = tbl[i].addr;
      wdata = tbl[i].data;
      wvalid = 1'b1;
      tick();
      if (tbl[i].we && tbl[i].sel == 2'd0) cnt_exp++;
      if (!tbl[i].we && tbl[i].addr[31:16] != 16'hdccc) err_exp = 1'b1;
      check($sformatf("vec%0d_we", i), buf_we, tbl[i].we);
      if (tbl[i].we) begin
        last_addr = tbl[i].waddr_exp;
        last_sel = tbl[i].sel;
        last_data = tbl[i].data;
      end
      check($sformatf("vec%0d_addr", i), buf_addr, last_addr);
      check($sformatf("vec%0d_sel", i), buf_sel, last_sel);
      check($sformatf("vec%0d_data", i), buf_wdata, last_data);
      check($sformatf("vec%0d_img_words", i), img_words, cnt_exp);
      check($sformatf("vec%0d_err", i), err, err_exp);
    end
    wvalid = 1'b0;
    tick();
    check("tbl_wready", wready, 1);
    check("tbl_no_start", cnn_start, 0);

    // Full load, launch, interrupt and relaunch with retained weights/bias.
    do_reset();
    pulse_done();
    tick();
    check("done_outside_run_irq", irq, 0);
    beat(32'hd3330000, 32'h11);
    beat(32'hd4440000, 32'h22);
    beat(32'hd5550000, 32'h33);
    beat(32'hdccc0000, 32'h1);
    beat(32'hdccc1111, 32'h1);
    beat(32'hdcccffff, 32'h1);
    check("runA_start_idx0", cnn_start, 0);
    check("runA_wready_idx0", wready, 1);
    waddr = 32'hd5550010;
    wdata = 32'hdead;
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("runA_start_idx1", cnn_start, 1);
    check("runA_wready_idx1", wready, 0);
    check("runA_late_beat_we", buf_we, 0);
    check("runA_late_beat_cnt", img_words, 1);
    tick();
    check("runA_start_idx2", cnn_start, 0);
    check("runA_late_beat_we2", buf_we, 0);
    pulse_clr();
    check("clr_in_run_irq", irq, 0);
    expect_start("runA_quiet", -1, 3);
    pulse_done();
    check("irq_set", irq, 1);
    tick();
    tick();
    check("irq_held", irq, 1);
    check("done_wready", wready, 0);
    pulse_clr();
    check("irq_cleared", irq, 0);
    check("clr_wready", wready, 1);
    check("clr_img_words", img_words, 0);
    beat(32'hd5550020, 32'h44);
    check("reload_we", buf_we, 1);
    check("reload_addr", buf_addr, 8);
    beat(32'hdcccffff, 32'h1);
    expect_start("runA_relaunch", 1, 5);
    check("runA_err", err, 0);

    // A mapping beat with data bit 0 clear must not set its flag.
    do_reset();
    beat(32'hd4440008, 32'h55);
    beat(32'hdccc0000, 32'h0);
    beat(32'hdccc1111, 32'h1);
    beat(32'hdcccffff, 32'h1);
    expect_start("map_zero", -1, 6);
    check("map_zero_err", err, 0);
    beat(32'hdccc0000, 32'h1);
    expect_start("map_one", 1, 4);

    // Reset during RUN.
    rst = 1'b0;
    tick();
    check("midrun_wready", wready, 0);
    check("midrun_buf_sel", buf_sel, 0);
    check("midrun_buf_addr", buf_addr, 0);
    check("midrun_buf_wdata", buf_wdata, 0);
    check("midrun_irq", irq, 0);
    check("midrun_start", cnn_start, 0);
    rst = 1'b1;
    tick();
    check("midrun_idle_wready", wready, 1);
    pulse_done();
    tick();
    check("midrun_no_irq", irq, 0);
    beat(32'hdcccffff, 32'h1);
    expect_start("midrun_no_start", -1, 6);

    // img_words saturates.
    do_reset();
    waddr = 32'hd5550000;
    wdata = 32'h7;
    wvalid = 1'b1;
    repeat (8195) tick();
    wvalid = 1'b0;
    tick();
    check("sat_img_words", img_words, 13'h1fff);

    // Randomized load phase against a behavioural model (image flag never mapped).
    do_reset();
    cnt_exp = 0;
    err_exp = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic        exp_we;
      logic [1:0]  exp_sel;
      logic [11:0] exp_addr;
      logic [31:0] a;
      logic [31:0] d;
      int          off;
      int          kind;
      logic [15:0] upper;
      exp_we = 1'b0;
      exp_sel = 2'd0;
      exp_addr = '0;
      d = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        kind = $urandom_range(0, 7);
        off = 0;
        case (kind)
          0: off = $urandom_range(0, 3071);
          1: off = $urandom_range(3072, 16383);
          2: off = $urandom_range(0, 1023);
          3: off = $urandom_range(1024, 16383);
          4: off = $urandom_range(0, 63);
          5: off = $urandom_range(64, 16383);
          default: off = 0;
        endcase
        case (kind)
          0, 1: a = 32'hd5550000;
          2, 3: a = 32'hd3330000;
          4, 5: a = 32'hd4440000;
          6: begin
            upper = 16'($urandom_range(0, 65535));
            if (upper == 16'hd555 || upper == 16'hd333 || upper == 16'hd444 || upper == 16'hdccc)
              upper = 16'h1234;
            a = {upper, 16'($urandom_range(0, 65535))};
          end
          default: a = ($urandom_range(0, 1) != 0) ? 32'hdccc0000 : 32'hdccc1111;
        endcase
        if (kind <= 5) a = a | (32'(off) << 2) | 32'($urandom_range(0, 3));
        if (kind == 0 || kind == 2 || kind == 4) begin
          exp_we = 1'b1;
          exp_sel = 2'(kind / 2);
          exp_addr = 12'(off);
          if (kind == 0 && cnt_exp < 8191) cnt_exp++;
        end else if (kind != 7) begin
          err_exp = 1'b1;
        end
        $display("rand %0d addr=%08h data=%08h", c, a, d);
        waddr = a;
        wdata = d;
        wvalid = 1'b1;
      end else begin
        wvalid = 1'b0;
      end
      tick();
      wvalid = 1'b0;
      check($sformatf("rand%0d_we", c), buf_we, exp_we);
      if (exp_we) begin
        check($sformatf("rand%0d_sel", c), buf_sel, exp_sel);
        check($sformatf("rand%0d_addr", c), buf_addr, exp_addr);
        check($sformatf("rand%0d_data", c), buf_wdata, d);
      end
      check($sformatf("rand%0d_img_words", c), img_words, cnt_exp);
      check($sformatf("rand%0d_err", c), err, err_exp);
      check($sformatf("rand%0d_wready", c), wready, 1);
      check($sformatf("rand%0d_start", c), cnn_start, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
